// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with frame-synchronous value commit,
// anti-ghosting blank gap at the start of each slot and optional leading-zero blanking.
module seg_scan_driver #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        E,
    output logic        F,
    output logic        G,
    output logic        dp,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_run;
    logic [15:0]   r_pend_val;
    logic [3:0]    r_pend_dp;
    logic          r_pend_v;
    logic [15:0]   r_act_val;
    logic [3:0]    r_act_dp;
    logic [6:0]    r_seg;
    logic          r_dp_slot;

    logic          w_slot_end;
    logic          w_wrap;
    logic          w_lit;
    logic [1:0]    w_next_idx;
    logic [15:0]   w_next_act;
    logic [3:0]    w_next_act_dp;
    logic [3:0]    w_nib;
    logic          w_blank;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // r_run stays low for the one cycle after reset so slot 0 (cnt=0) begins on the first edge
    assign w_slot_end = r_run && (r_cnt == CW'(DIV - 1));
    assign w_wrap     = w_slot_end && (r_idx == 2'd3);
    assign w_lit      = r_run && (r_cnt >= CW'(BLANK_CYC));

    // Values seen by the slot that starts on the coming edge (commit included)
    always_comb begin
        w_next_idx    = r_run ? (r_idx + 2'd1) : 2'd0;
        w_next_act    = r_act_val;
        w_next_act_dp = r_act_dp;
        if (w_wrap && r_pend_v) begin
            w_next_act    = r_pend_val;
            w_next_act_dp = r_pend_dp;
        end
        w_nib   = w_next_act[3:0];
        w_blank = 1'b0;
        case (w_next_idx)
            2'd0: begin
                w_nib   = w_next_act[3:0];
                w_blank = 1'b0;
            end
            2'd1: begin
                w_nib   = w_next_act[7:4];
                w_blank = blank_lz && (w_next_act[15:4] == 12'd0);
            end
            2'd2: begin
                w_nib   = w_next_act[11:8];
                w_blank = blank_lz && (w_next_act[15:8] == 8'd0);
            end
            default: begin
                w_nib   = w_next_act[15:12];
                w_blank = blank_lz && (w_next_act[15:12] == 4'd0);
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else begin
            r_run <= 1'b1;
            if (w_slot_end) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else if (r_run) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A load on the commit edge lands in pending after the old pending has been committed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_val <= 16'd0;
            r_pend_dp  <= 4'd0;
            r_pend_v   <= 1'b0;
            r_act_val  <= 16'd0;
            r_act_dp   <= 4'd0;
        end else begin
            if (w_wrap && r_pend_v) begin
                r_act_val <= r_pend_val;
                r_act_dp  <= r_pend_dp;
            end
            if (load) begin
                r_pend_val <= value;
                r_pend_dp  <= dp_in;
                r_pend_v   <= 1'b1;
            end else if (w_wrap) begin
                r_pend_v   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg     <= 7'd0;
            r_dp_slot <= 1'b0;
        end else if (w_slot_end || !r_run) begin
            r_seg     <= w_blank ? 7'd0 : hex7(w_nib);
            r_dp_slot <= w_next_act_dp[w_next_idx];
        end
    end

    assign {A, B, C, D, E, F, G} = r_seg;
    assign dp                    = r_dp_slot & w_lit;
    assign digit                 = w_lit ? (4'b0001 << r_idx) : 4'b0000;
    assign frame_done            = w_wrap;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed display scenarios plus random loads, checked every
// cycle against a frame/slot-timeline reference model.
module tb_seg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        A, B, C, D, E, F, G, dp, frame_done;
    logic [3:0]  digit;

    int n_vec = 0;
    int n_err = 0;

    // Model state: time since first slot, displayed/pending contents, per-slot latched view
    bit          m_run;
    int          m_t;
    logic [15:0] m_act, m_pval;
    logic [3:0]  m_adp, m_pdp;
    bit          m_pv;
    logic [6:0]  m_seg;
    bit          m_dp;
    logic [6:0]  seg_tab [16];
    bit          g_blz;

    seg_scan_driver #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .blank_lz(blank_lz), .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
        .dp(dp), .digit(digit), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (time %0t, model t=%0d)", tag, got, exp, $time, m_t);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0;
        m_act = 0; m_adp = 0; m_pval = 0; m_pdp = 0; m_pv = 0;
        m_seg = 0; m_dp = 0;
    endtask

    task automatic latch_slot(input int slot, input bit blz);
        logic [15:0] upper;
        upper = m_act >> (4 * slot);
        if (blz && slot > 0 && upper == 16'd0) m_seg = 7'd0;
        else m_seg = seg_tab[upper[3:0]];
        m_dp = m_adp[slot];
    endtask

    task automatic check_outputs();
        int slot, c;
        bit lit;
        logic [3:0] e_dig;
        if (!m_run) begin
            chk("seg_idle", {A, B, C, D, E, F, G}, 0);
            chk("digit_idle", digit, 0);
            chk("dp_idle", dp, 0);
            chk("fd_idle", frame_done, 0);
        end else begin
            slot  = (m_t / DIV) % 4;
            c     = m_t % DIV;
            lit   = (c >= BLANK);
            e_dig = lit ? (4'b0001 << slot) : 4'b0000;
            chk("seg", {A, B, C, D, E, F, G}, m_seg);
            chk("digit", digit, e_dig);
            chk("dp", dp, m_dp & lit);
            chk("frame_done", frame_done, (m_t % FRAME) == FRAME - 1);
        end
    endtask

    task automatic model_edge(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit blz);
        if (!m_run) begin
            m_run = 1; m_t = 0;
            latch_slot(0, blz);
        end else begin
            if ((m_t % FRAME) == FRAME - 1 && m_pv) begin
                m_act = m_pval; m_adp = m_pdp; m_pv = 0;
            end
            m_t++;
            if (m_t % DIV == 0) latch_slot((m_t / DIV) % 4, blz);
        end
        if (ld) begin
            m_pval = v; m_pdp = d; m_pv = 1;
        end
    endtask

    // Called at a falling edge: check, then drive inputs for the coming rising edge
    task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
        check_outputs();
        load = ld; value = v; dp_in = d; blank_lz = g_blz;
        model_edge(ld, v, d, g_blz);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, $urandom, $urandom);
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME + 2; i++) begin
            if (m_run && (m_t % FRAME) == ph) break;
            step(0, 16'd0, 4'd0);
        end
    endtask

    initial begin
        seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        rst = 1'b1; load = 0; value = 0; dp_in = 0; blank_lz = 0; g_blz = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Power-up display of zeros, first frame_done 31 cycles into the scan
        idle(70);

        // Mid-frame load with a decimal point on digit 2
        run_to_phase(10);
        step(1, 16'h1A3F, 4'b0100);
        idle(75);

        // Leading-zero blanking on and off
        g_blz = 1;
        run_to_phase(3);
        step(1, 16'h0070, 4'b0000);
        idle(70);
        g_blz = 0;
        idle(40);

        // Two loads in one frame: only the last is committed
        run_to_phase(5);
        step(1, 16'h1111, 4'b0000);
        run_to_phase(20);
        step(1, 16'h2222, 4'b0000);
        idle(70);

        // Load on the frame_done cycle while a value is pending
        run_to_phase(10);
        step(1, 16'h4444, 4'b0000);
        run_to_phase(FRAME - 1);
        step(1, 16'h5555, 4'b0000);
        idle(70);

        // Asynchronous reset while digit 2 is lit
        g_blz = 1;
        run_to_phase(2 * DIV + 4);
        chk("pre_rst_digit", digit, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("async_seg", {A, B, C, D, E, F, G}, 0);
        chk("async_digit", digit, 0);
        chk("async_dp", dp, 0);
        chk("async_fd", frame_done, 0);
        model_reset();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
        idle(40);

        // Random loads, values rich in zero nibbles, random blanking level
        for (int i = 0; i < 800; i++) begin
            logic [15:0] v;
            v = $urandom;
            v = v & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                     {4{$urandom_range(0, 1) == 1}}, {4{1'b1}}};
            if ($urandom_range(0, 63) == 0) g_blz = ~g_blz;
            step($urandom_range(0, 9) == 0, v, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
